// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register-write arbiter.
package reg_arb_pkg;
  localparam int N_DEF       = 8;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;
endpackage

// File: rtl/register_synch_reset_load_nbit.sv
// N-bit register with synchronous active-low reset and load enable.
module register_synch_reset_load_nbit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_b)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester with req set, starting at ptr.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      idx
);

  int cand;

  // Walk offsets from the far end down so the closest hit to ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time a write into a shared register.
// state | meaning
// IDLE  | arbitrate among pending requests
// LOAD  | write issued, load_o/ack/busy high for this single cycle
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N       = N_DEF,
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*N-1:0] data_i,
  output logic [N-1:0]         d_o,
  output logic                 load_o,
  output logic [NUM_REQ-1:0]   ack,
  output logic [PW-1:0]        grant_id,
  output logic                 busy
);

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic          armed;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          grant;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // armed holds off arbitration for one edge after reset release.
  assign grant = (state == IDLE) && armed && pick_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      ptr      <= '0;
      d_o      <= '0;
      load_o   <= 1'b0;
      ack      <= '0;
      grant_id <= '0;
    end else begin
      armed  <= 1'b1;
      load_o <= 1'b0;
      ack    <= '0;
      if (grant) begin
        d_o      <= data_i[int'(pick_idx)*N +: N];
        grant_id <= pick_idx;
        load_o   <= 1'b1;
        ack      <= NUM_REQ'(1) << pick_idx;
        ptr      <= (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
      end
    end
  end

  assign busy = (state == LOAD);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter driving a shared register.
module tb_reg_write_arbiter;
  localparam int N  = 8;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*N-1:0] data_i = '0;
  logic [N-1:0]  d_o;
  logic          load_o;
  logic [NR-1:0] ack;
  logic [1:0]    grant_id;
  logic          busy;
  logic [N-1:0]  q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_i   (data_i),
    .d_o      (d_o),
    .load_o   (load_o),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  register_synch_reset_load_nbit #(.N(N)) u_reg (
    .clk   (clk),
    .rst_b (~rst),
    .load  (load_o),
    .d     (d_o),
    .q     (q)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    step();
    checks++; if (load_o !== 1'b0) begin errors++; $display("FAIL reset_load: got %b exp 0", load_o); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    checks++; if (d_o !== 8'h00) begin errors++; $display("FAIL reset_d: got %h exp 00", d_o); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d exp 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h exp 00", q); end
    // Request present at release: first edge must not grant, second must.
    req = 4'b0001; data_i = {8'h04, 8'h03, 8'h02, 8'h01};
    rst = 1'b0;
    step();
    checks++; if (load_o !== 1'b0) begin errors++; $display("FAIL reset_first_edge_load: got %b exp 0", load_o); end
    step();
    checks++; if (load_o !== 1'b1 || ack !== 4'b0001) begin errors++; $display("FAIL reset_second_edge_grant: got load=%b ack=%b exp 1 0001", load_o, ack); end
    req = '0;
    step();
  endtask

  // ptr is 1 on entry.
  task automatic test_single();
    data_i = {8'h00, 8'hA5, 8'h00, 8'h00};
    req = 4'b0100;
    step();
    checks++; if (load_o !== 1'b1) begin errors++; $display("FAIL single_load: got %b exp 1", load_o); end
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b exp 0100", ack); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid: got %0d exp 2", grant_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
    checks++; if (d_o !== 8'hA5) begin errors++; $display("FAIL single_d: got %h exp a5", d_o); end
    req = '0;
    step();
    checks++; if (load_o !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got load=%b ack=%b busy=%b exp 0 0000 0", load_o, ack, busy); end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h exp a5", q); end
  endtask

  // ptr is 3 on entry.
  task automatic test_wrap();
    data_i = {8'h00, 8'h00, 8'h21, 8'h20};
    req = 4'b0011;
    step();
    checks++; if (grant_id !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got gid=%0d ack=%b exp 0 0001", grant_id, ack); end
    checks++; if (d_o !== 8'h20) begin errors++; $display("FAIL wrap_d0: got %h exp 20", d_o); end
    req = 4'b0010;
    step();
    step();
    checks++; if (grant_id !== 2'd1 || ack !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1: got gid=%0d ack=%b exp 1 0010", grant_id, ack); end
    req = '0;
    step();
  endtask

  task automatic test_all_requesting();
    rst = 1'b1;
    data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (load_o !== 1'b1 || grant_id !== 2'(i % 4)) begin errors++; $display("FAIL all_grant%0d: got load=%b gid=%0d exp 1 %0d", i, load_o, grant_id, i % 4); end
      checks++; if (d_o !== 8'(8'h10 + i % 4)) begin errors++; $display("FAIL all_d%0d: got %h exp %h", i, d_o, 8'(8'h10 + i % 4)); end
      checks++; if (ack !== 4'(1 << (i % 4))) begin errors++; $display("FAIL all_ack%0d: got %b exp %b", i, ack, 4'(1 << (i % 4))); end
      if (i == 4) req = '0;
      step();
      checks++; if (load_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL all_gap%0d: got load=%b busy=%b exp 0 0", i, load_o, busy); end
    end
  endtask

  // ptr is 1 on entry.
  task automatic test_req_during_load();
    data_i = {8'h33, 8'h00, 8'h00, 8'h30};
    req = 4'b0001;
    step();
    checks++; if (grant_id !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL dload_grant0: got gid=%0d ack=%b exp 0 0001", grant_id, ack); end
    req = 4'b1000;
    step();
    checks++; if (load_o !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL dload_ignored: got load=%b ack=%b busy=%b exp 0 0000 0", load_o, ack, busy); end
    step();
    checks++; if (grant_id !== 2'd3 || ack !== 4'b1000 || d_o !== 8'h33) begin errors++; $display("FAIL dload_grant3: got gid=%0d ack=%b d=%h exp 3 1000 33", grant_id, ack, d_o); end
    req = '0;
    step();
    checks++; if (ack !== 4'b0000 || load_o !== 1'b0) begin errors++; $display("FAIL dload_no_dup: got ack=%b load=%b exp 0000 0", ack, load_o); end
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL dload_no_dup2: got ack=%b exp 0000", ack); end
  endtask

  task automatic test_mid_reset();
    data_i = {8'h00, 8'h77, 8'h00, 8'h3C};
    req = 4'b0100;
    step();
    checks++; if (load_o !== 1'b1) begin errors++; $display("FAIL mreset_in_load: got %b exp 1", load_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (load_o !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL mreset_async: got load=%b ack=%b exp 0 0000", load_o, ack); end
    checks++; if (d_o !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL mreset_d_busy: got d=%h busy=%b exp 00 0", d_o, busy); end
    rst = 1'b0;
    req = 4'b0001;
    step();
    checks++; if (load_o !== 1'b0) begin errors++; $display("FAIL mreset_hold: got %b exp 0", load_o); end
    step();
    checks++; if (grant_id !== 2'd0 || ack !== 4'b0001 || d_o !== 8'h3C) begin errors++; $display("FAIL mreset_regrant: got gid=%0d ack=%b d=%h exp 0 0001 3c", grant_id, ack, d_o); end
    req = '0;
    step();
  endtask

  task automatic test_idle();
    req = '0;
    data_i = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (load_o !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_outs%0d: got load=%b ack=%b busy=%b exp 0 0000 0", i, load_o, ack, busy); end
      checks++; if (d_o !== 8'h3C || q !== 8'h3C) begin errors++; $display("FAIL idle_hold%0d: got d=%h q=%h exp 3c 3c", i, d_o, q); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_all_requesting();
    test_req_during_load();
    test_mid_reset();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The parameter N SHALL default to 8 and set the data width of each requester word and of the shared register.
REQ-002 The parameter NUM_REQ SHALL default to 4 and set the number of requesters, with a legal range of 2..8.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide; reset is asynchronous and active-high.
REQ-005 Port req SHALL be an input, NUM_REQ bits wide, with one bit per requester asking to write.
REQ-006 Port data_i SHALL be an input, NUM_REQ*N bits wide; requester i's word is bits [i*N +: N].
REQ-007 Port d_o SHALL be an output, N bits wide, and drives D of the shared register.
REQ-008 Port load_o SHALL be an output, 1 bit wide, and drives load of the shared register.
REQ-009 Port ack SHALL be an output, NUM_REQ bits wide, and pulses for one cycle to the granted requester.
REQ-010 Port grant_id SHALL be an output, $clog2(NUM_REQ) bits wide, and gives the index of the last granted requester.
REQ-011 Port busy SHALL be an output, 1 bit wide, and is high while the FSM is in LOAD.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (arbitrate) and LOAD (write issued).
REQ-013 In IDLE with req!=0, the arbiter SHALL pick the first requester with req set, searching from ptr upward modulo NUM_REQ, and SHALL go to LOAD at the next edge.
REQ-014 On the IDLE->LOAD edge, the block SHALL register d_o <= word of the winner, grant_id <= winner, ack[winner] <= 1 and load_o <= 1.
REQ-015 In LOAD, load_o, busy and the single ack bit SHALL be high for exactly one cycle; at the next edge the FSM SHALL return to IDLE with load_o=0 and ack=0.
REQ-016 Latency SHALL be as follows: req sampled high at edge k gives load_o/ack high during cycle k+1; worst-case wait for a continuously requesting port is 2*NUM_REQ cycles.
REQ-017 Throughput SHALL be at most one write per 2 cycles; no arbitration SHALL occur in LOAD, and req changes during LOAD SHALL be ignored.
REQ-018 On each grant, ptr SHALL become (winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-019 In IDLE with req==0, the block SHALL remain in IDLE with all outputs holding their values except load_o=0, ack=0 and busy=0.
REQ-020 d_o SHALL hold the last written word between grants.
REQ-021 Handshake: a requester SHALL keep req and its word stable until it sees ack, and SHALL drop req the cycle after ack if it has no further write; a req still high in IDLE after ack is treated as a new request.
REQ-022 If all requesters are active simultaneously, the grant order from reset SHALL be 0,1,2,...,NUM_REQ-1,0,...

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, ptr=0, d_o=0, load_o=0, ack=0, grant_id=0 and busy=0, independent of clk.
REQ-024 Reset asserted during LOAD SHALL abort the write: load_o drops asynchronously, and the requester is not acked and must re-request.
REQ-025 The first grant after reset deassertion SHALL occur no earlier than the second rising edge after rst falls.

Structure
REQ-026 Package reg_arb_pkg SHALL hold the state enum type (IDLE, LOAD) and the default constants for N and NUM_REQ.
REQ-027 The round-robin search SHALL be a combinational sub-module rr_picker (inputs req and ptr; outputs valid and idx); the FSM and output registers live in reg_write_arbiter.
REQ-028 The bench top SHALL connect d_o/load_o to register_synch_reset_load_nbit with its reset tied to the inverted rst.

Verification
REQ-029 Single request: req=4'b0100 with word 2 = 8'hA5 -> load_o and ack=4'b0100 during cycle k+1, grant_id=2, register Q=8'hA5 after that edge.
REQ-030 All requesting: req=4'b1111 with words 8'h10/11/12/13 held -> grants in order 0,1,2,3,0 on every second cycle, and d_o follows the same sequence.
REQ-031 Wrap-around: ptr=3 after granting 2, req=4'b0011 -> requester 0 is granted, then ptr=1.
REQ-032 Request during LOAD: req 0 is granted and req 3 rises during LOAD -> req 3 is ignored until IDLE, then granted with no lost or duplicate ack.
REQ-033 Mid-operation reset: rst pulsed during LOAD -> load_o=0, ack=0 and d_o=8'h00 without waiting for a clock edge; after release, req=4'b0001 -> requester 0 is granted.
REQ-034 Idle: req=0 for 10 cycles -> load_o, ack and busy stay 0, and d_o is unchanged.
